// File: rtl/csi_rx_byte_align.sv
`default_nettype none
// ============================================================================
//  Module      : csi_rx_byte_align
//  Description : Per-lane D-PHY HS byte aligner. Hunts all eight bit offsets
//                of the deserialized stream for the SoT sync byte, locks the
//                winning offset and streams aligned payload bytes until the
//                packet ends. Optional macro CSI_RX_ALIGN_SOFT_SYNC_EN also
//                accepts a sync byte with a single bit error.
//  Revision    : 1.0 - initial release
// ============================================================================
module csi_rx_byte_align #(
    parameter logic [7:0] SYNC_BYTE = 8'hB8,
    parameter logic       INVERT_IN = 1'b0
) (
    input  logic       byte_clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       wait_for_sync,
    input  logic       packet_done,
    input  logic [7:0] deser_in,
    output logic [7:0] data_out,
    output logic       data_vld,
    output logic       locked,
    output logic [2:0] offset,
    output logic       sot_err_soft
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  prev_q;
    logic [7:0]  data_q, data_d;
    logic        vld_q, vld_d;
    logic        locked_q, locked_d;
    logic [2:0]  offset_q, offset_d;
    logic        soft_q, soft_d;

    logic [7:0]  w_in;
    logic [14:0] w_win;
    logic [7:0]  w_cand [8];
    logic [7:0]  w_exact;
    logic [7:0]  w_vec;
    logic        w_hit;
    logic        w_hit_soft;
    logic [2:0]  w_hit_k;

    assign w_in  = INVERT_IN ? ~deser_in : deser_in;
    // Window in time order, oldest bit at 0; the newest bit is never the
    // start of any candidate so it is left out.
    assign w_win = {w_in[6:0], prev_q};

    genvar gk;
    generate
        for (gk = 0; gk < 8; gk++) begin : g_cand
            assign w_cand[gk]  = w_win[gk+7:gk];
            assign w_exact[gk] = (w_cand[gk] == SYNC_BYTE);
        end
    endgenerate

`ifdef CSI_RX_ALIGN_SOFT_SYNC_EN
    logic [7:0] w_soft;
    generate
        for (gk = 0; gk < 8; gk++) begin : g_soft
            logic [7:0] w_x;
            assign w_x        = w_cand[gk] ^ SYNC_BYTE;
            assign w_soft[gk] = (w_x != 8'd0) && ((w_x & (w_x - 8'd1)) == 8'd0);
        end
    endgenerate
    // Any exact hit anywhere masks every single-error candidate.
    assign w_vec      = (|w_exact) ? w_exact : w_soft;
    assign w_hit_soft = ~(|w_exact);
`else
    assign w_vec      = w_exact;
    assign w_hit_soft = 1'b0;
`endif

    assign w_hit = |w_vec;

    always_comb begin
        w_hit_k = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (w_vec[k]) begin
                w_hit_k = 3'(k);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        vld_d    = 1'b0;
        offset_d = offset_q;
        soft_d   = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wait_for_sync) begin
                        state_d = ST_HUNT;
                    end
                end
                ST_HUNT: begin
                    if (!packet_done && wait_for_sync && w_hit) begin
                        state_d  = ST_LOCKED;
                        offset_d = w_hit_k;
                        soft_d   = w_hit_soft;
                    end
                end
                ST_LOCKED: begin
                    if (packet_done) begin
                        state_d = ST_HUNT;
                    end else begin
                        vld_d  = 1'b1;
                        data_d = w_cand[offset_q];
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge byte_clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            prev_q   <= 8'd0;
            data_q   <= 8'd0;
            vld_q    <= 1'b0;
            locked_q <= 1'b0;
            offset_q <= 3'd0;
            soft_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= w_in;
            data_q   <= data_d;
            vld_q    <= vld_d;
            locked_q <= locked_d;
            offset_q <= offset_d;
            soft_q   <= soft_d;
        end
    end

    assign data_out     = data_q;
    assign data_vld     = vld_q;
    assign locked       = locked_q;
    assign offset       = offset_q;
    assign sot_err_soft = soft_q;

endmodule
`default_nettype wire

// File: tb/tb_csi_rx_byte_align.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csi_rx_byte_align
//  Description : Directed bench for csi_rx_byte_align with a bit-stream
//                reference model and hand-computed spot checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csi_rx_byte_align;

    localparam logic [7:0] SYNC = 8'hB8;
    localparam logic       INV  = 1'b0;

    logic       byte_clock = 1'b0;
    logic       reset = 1'b1, enable = 1'b0, wait_for_sync = 1'b0, packet_done = 1'b0;
    logic [7:0] deser_in = 8'h00;
    logic [7:0] data_out;
    logic       data_vld, locked, sot_err_soft;
    logic [2:0] offset;

    csi_rx_byte_align #(.SYNC_BYTE(SYNC), .INVERT_IN(INV)) dut (
        .byte_clock   (byte_clock),
        .reset        (reset),
        .enable       (enable),
        .wait_for_sync(wait_for_sync),
        .packet_done  (packet_done),
        .deser_in     (deser_in),
        .data_out     (data_out),
        .data_vld     (data_vld),
        .locked       (locked),
        .offset       (offset),
        .sot_err_soft (sot_err_soft)
    );

    always #5 byte_clock = ~byte_clock;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_on  = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: every received bit is kept in arrival order; a lock
    // fixes an absolute bit position and payload bytes are cut from there.
    bit         hist[$];
    int         mode = 0;          // 0 idle, 1 hunt, 2 locked
    int         nextpos = 0;
    logic [7:0] m_data = 8'h00;
    logic       m_vld = 1'b0, m_lock = 1'b0, m_sot = 1'b0;
    logic [2:0] m_off = 3'd0;

    function automatic logic [7:0] grab(input int pos);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = hist[pos+i];
        return b;
    endfunction

    function automatic int hdist(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        for (int i = 0; i < 8; i++) if (a[i] != b[i]) n++;
        return n;
    endfunction

    initial for (int i = 0; i < 8; i++) hist.push_back(1'b0);

    always @(posedge byte_clock) begin
        logic [7:0] bin;
        int base, found;
        bin = reset ? 8'h00 : (deser_in ^ {8{INV}});
        for (int i = 0; i < 8; i++) hist.push_back(bin[i]);
        base  = hist.size() - 16;
        m_sot = 1'b0;
        if (reset) begin
            mode = 0; m_data = 8'h00; m_vld = 1'b0; m_lock = 1'b0; m_off = 3'd0;
        end else if (!enable) begin
            mode = 0; m_vld = 1'b0; m_lock = 1'b0;
        end else if (mode == 0) begin
            if (wait_for_sync) mode = 1;
        end else if (mode == 1) begin
            if (!packet_done && wait_for_sync) begin
                found = -1;
                for (int k = 7; k >= 0; k--) if (grab(base+k) == SYNC) found = k;
`ifdef CSI_RX_ALIGN_SOFT_SYNC_EN
                if (found < 0) begin
                    for (int k = 7; k >= 0; k--) if (hdist(grab(base+k), SYNC) == 1) found = k;
                    if (found >= 0) m_sot = 1'b1;
                end
`endif
                if (found >= 0) begin
                    mode = 2; m_lock = 1'b1; m_off = 3'(found);
                    nextpos = base + found + 8;
                end
            end
        end else begin
            if (packet_done) begin
                mode = 1; m_lock = 1'b0; m_vld = 1'b0;
            end else begin
                m_vld = 1'b1; m_data = grab(nextpos); nextpos += 8;
            end
        end
    end

    always @(negedge byte_clock) begin
        if (cmp_on) begin
            check("cyc data_out", {24'd0, data_out}, {24'd0, m_data});
            check("cyc data_vld", {31'd0, data_vld}, {31'd0, m_vld});
            check("cyc locked", {31'd0, locked}, {31'd0, m_lock});
            check("cyc offset", {29'd0, offset}, {29'd0, m_off});
            check("cyc sot_err_soft", {31'd0, sot_err_soft}, {31'd0, m_sot});
        end
    end

    // Stimulus helpers
    logic [7:0] txq[$];
    logic [7:0] cap_dat [16];
    logic       cap_vld [16];
    logic       cap_lock[16];
    logic [2:0] cap_off [16];
    logic       cap_sot [16];

    task automatic cyc(input logic [7:0] d, input logic e, input logic w,
                       input logic p, input logic r);
        deser_in = d; enable = e; wait_for_sync = w; packet_done = p; reset = r;
        @(negedge byte_clock);
    endtask

    task automatic arm();
        cyc(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic play(input int pd_at, input int drop_at, input int rst_at, input logic w);
        for (int i = 0; i < txq.size(); i++) begin
            cyc(txq[i], (i < drop_at), w, (i == pd_at), (i == rst_at));
            cap_dat[i] = data_out; cap_vld[i] = data_vld; cap_lock[i] = locked;
            cap_off[i] = offset;   cap_sot[i] = sot_err_soft;
        end
    endtask

    task automatic build_pkt(input int shift, input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input logic [7:0] p3);
        bit bq[$];
        logic [7:0] seq[5];
        logic [7:0] w;
        seq = '{SYNC, p0, p1, p2, p3};
        for (int i = 0; i < 16 + shift; i++) bq.push_back(1'b0);
        for (int j = 0; j < 5; j++) for (int i = 0; i < 8; i++) bq.push_back(seq[j][i]);
        while (bq.size() < 80) bq.push_back(1'b0);
        txq.delete();
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < 8; i++) w[i] = bq[8*j+i];
            txq.push_back(w);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pl[4];
        pl = '{8'h5A, 8'hA5, 8'hFF, 8'h00};

        // Reset with random data
        for (int i = 0; i < 3; i++) cyc(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
        cmp_on = 1'b1;
        check("reset data_out", {24'd0, data_out}, 32'h0);
        check("reset data_vld", {31'd0, data_vld}, 32'h0);
        check("reset locked", {31'd0, locked}, 32'h0);
        check("reset offset", {29'd0, offset}, 32'h0);
        check("reset sot", {31'd0, sot_err_soft}, 32'h0);
        for (int i = 0; i < 2; i++) cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Offset 0
        arm();
        txq = '{8'h00, 8'h00, 8'hB8, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00};
        play(6, 99, -1, 1'b1);
        check("off0 lock edge locked", {31'd0, cap_lock[3]}, 32'h1);
        check("off0 lock edge vld", {31'd0, cap_vld[3]}, 32'h0);
        check("off0 byte0", {23'd0, cap_vld[4], cap_dat[4]}, 32'h112);
        check("off0 byte1", {23'd0, cap_vld[5], cap_dat[5]}, 32'h134);
        check("off0 offset", {29'd0, cap_off[5]}, 32'h0);
        check("off0 vld after done", {31'd0, cap_vld[6]}, 32'h0);
        check("off0 unlock after done", {31'd0, cap_lock[6]}, 32'h0);

        // Offset 3: sync straddles words 1 and 2
        arm();
        txq = '{8'h00, 8'hC0, 8'h95, 8'hA0, 8'h01, 8'h00, 8'h00};
        play(5, 99, -1, 1'b1);
        check("off3 lock edge", {30'd0, cap_lock[2], cap_vld[2]}, 32'h2);
        check("off3 byte0", {23'd0, cap_vld[3], cap_dat[3]}, 32'h112);
        check("off3 byte1", {23'd0, cap_vld[4], cap_dat[4]}, 32'h134);
        check("off3 offset", {29'd0, cap_off[4]}, 32'h3);
        check("off3 vld after done", {31'd0, cap_vld[5]}, 32'h0);

        // Sweep all offsets
        for (int s = 0; s < 8; s++) begin
            arm();
            build_pkt(s, pl[0], pl[1], pl[2], pl[3]);
            play(8, 99, -1, 1'b1);
            check($sformatf("sweep%0d offset", s), {29'd0, cap_off[4]}, s);
            for (int b = 0; b < 4; b++)
                check($sformatf("sweep%0d byte%0d", s, b),
                      {23'd0, cap_vld[4+b], cap_dat[4+b]}, {23'd0, 1'b1, pl[b]});
            check($sformatf("sweep%0d vld after done", s), {31'd0, cap_vld[8]}, 32'h0);
        end

        // Enable dropped mid-payload, then relock at a new offset
        arm();
        build_pkt(5, 8'h11, 8'h22, 8'h33, 8'h44);
        play(-1, 5, -1, 1'b1);
        check("abort byte0", {23'd0, cap_vld[4], cap_dat[4]}, 32'h111);
        check("abort vld", {31'd0, cap_vld[5]}, 32'h0);
        check("abort locked", {31'd0, cap_lock[5]}, 32'h0);
        arm();
        build_pkt(6, 8'hC3, 8'h3C, 8'h81, 8'h7E);
        play(8, 99, -1, 1'b1);
        check("relock offset", {29'd0, cap_off[4]}, 32'h6);
        check("relock byte0", {23'd0, cap_vld[4], cap_dat[4]}, 32'h1C3);
        check("relock byte3", {23'd0, cap_vld[7], cap_dat[7]}, 32'h17E);

        // Reset mid-packet
        arm();
        build_pkt(2, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
        play(-1, 5, 5, 1'b1);
        check("rst byte0", {23'd0, cap_vld[4], cap_dat[4]}, 32'h1DE);
        check("rst outputs", {20'd0, cap_dat[5], cap_vld[5], cap_lock[5], cap_off[5]}, 32'h0);
        check("rst no byte after", {31'd0, cap_vld[6]}, 32'h0);
        for (int i = 0; i < 2; i++) cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Sync ignored while wait_for_sync is low in HUNT
        arm();
        txq = '{8'h00, 8'h00, 8'hB8, 8'h12, 8'h34, 8'h00};
        play(-1, 99, -1, 1'b0);
        check("nowfs locked", {31'd0, cap_lock[3]}, 32'h0);
        check("nowfs vld", {31'd0, cap_vld[4]}, 32'h0);

        // packet_done on the match cycle blocks the lock
        arm();
        txq = '{8'h00, 8'h00, 8'hB8, 8'h12, 8'h34, 8'h00};
        play(3, 99, -1, 1'b1);
        check("pd+match locked", {31'd0, cap_lock[3]}, 32'h0);
        check("pd+match vld", {31'd0, cap_vld[4]}, 32'h0);

        // Single-bit-error sync
        arm();
        txq = '{8'h00, 8'hB9, 8'h77, 8'h00, 8'h00, 8'h00};
        play(4, 99, -1, 1'b1);
`ifdef CSI_RX_ALIGN_SOFT_SYNC_EN
        check("soft locked", {31'd0, cap_lock[2]}, 32'h1);
        check("soft pulse", {30'd0, cap_sot[2], cap_sot[3]}, 32'h2);
        check("soft byte0", {23'd0, cap_vld[3], cap_dat[3]}, 32'h177);
        check("soft offset", {29'd0, cap_off[3]}, 32'h0);
`else
        check("soft no lock", {31'd0, cap_lock[2]}, 32'h0);
        check("soft no vld", {31'd0, cap_vld[3]}, 32'h0);
        check("soft no pulse", {31'd0, cap_sot[2]}, 32'h0);
`endif

        cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
